// File: rtl/cim_sas_sequencer.sv
// Bit-serial sequencer for the CIM Shift_and_Add block: one ADC fetch and one
// in_valid beat per input bit, each beat acknowledged by out_valid or timed out.
module cim_sas_sequencer #(
    parameter int BIT_CELL       = 1,
    parameter int BIT_DAC        = 1,
    parameter int BIT_W          = 8,
    parameter int OUY            = 8,
    parameter int BIT_IFM        = 8,
    parameter int MAX_NUM_FILTER = 32,
    parameter int MAX_WAIT       = 100,
    localparam int ADC_PRECISION = BIT_CELL + BIT_DAC + $clog2(OUY)
                                   - (((BIT_CELL == 1) || (BIT_DAC == 1)) ? 1 : 0),
    localparam int BIT_ONES_COUNTER       = $clog2(OUY),
    localparam int BIT_INPUT_BIT_POSITION = $clog2(BIT_IFM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [OUY*BIT_IFM-1:0]              ifm_in,
    input  logic [MAX_NUM_FILTER*BIT_W-1:0]     weight_pos_in,
    output logic                                adc_req,
    output logic [BIT_INPUT_BIT_POSITION-1:0]   adc_bit,
    input  logic                                adc_valid,
    input  logic [ADC_PRECISION-1:0]            adc_data,
    output logic                                in_valid,
    output logic [ADC_PRECISION-1:0]            ADC_RESULT,
    output logic [MAX_NUM_FILTER*BIT_W-1:0]     WEIGHT_BIT_POSITION,
    output logic [BIT_ONES_COUNTER-1:0]         ONES_COUNTER,
    output logic [BIT_INPUT_BIT_POSITION-1:0]   INPUT_BIT_POSITION,
    input  logic                                out_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                timeout_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT);
    localparam logic [BIT_INPUT_BIT_POSITION-1:0] LAST_BIT = BIT_INPUT_BIT_POSITION'(BIT_IFM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                              r_state;
    state_t                              w_next_state;
    logic [OUY*BIT_IFM-1:0]              r_ifm;
    logic [MAX_NUM_FILTER*BIT_W-1:0]     r_wpos;
    logic [BIT_INPUT_BIT_POSITION-1:0]   r_bit;
    logic [WAIT_W-1:0]                   r_wait_cnt;
    logic [ADC_PRECISION-1:0]            r_adc;
    logic                                r_timeout_err;
    logic [BIT_ONES_COUNTER-1:0]         w_ones;
    logic                                w_last_bit;
    logic                                w_wait_expired;

    assign w_last_bit     = (r_bit == LAST_BIT);
    assign w_wait_expired = (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign timeout_err    = r_timeout_err;

    // Ones count of the current bit slice; truncation to the port width is intended.
    always_comb begin
        w_ones = '0;
        for (int r = 0; r < OUY; r++) begin
            w_ones = w_ones + BIT_ONES_COUNTER'(r_ifm[r*BIT_IFM + int'(r_bit)]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_next_state        = r_state;
        adc_req             = 1'b0;
        adc_bit             = '0;
        in_valid            = 1'b0;
        ADC_RESULT          = '0;
        WEIGHT_BIT_POSITION = '0;
        ONES_COUNTER        = '0;
        INPUT_BIT_POSITION  = '0;
        busy                = 1'b0;
        done                = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_REQ;
            end
            S_REQ: begin
                busy    = 1'b1;
                adc_req = 1'b1;
                adc_bit = r_bit;
                if (adc_valid) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                busy                = 1'b1;
                in_valid            = 1'b1;
                ADC_RESULT          = r_adc;
                WEIGHT_BIT_POSITION = r_wpos;
                ONES_COUNTER        = w_ones;
                INPUT_BIT_POSITION  = r_bit;
                w_next_state        = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (out_valid) begin
                    w_next_state = w_last_bit ? S_DONE : S_REQ;
                end else if (w_wait_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the latched slice and weights are reset as well, so a reset mid-run leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifm         <= '0;
            r_wpos        <= '0;
            r_bit         <= '0;
            r_wait_cnt    <= '0;
            r_adc         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ifm         <= ifm_in;
                        r_wpos        <= weight_pos_in;
                        r_bit         <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (adc_valid) r_adc <= adc_data;
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (out_valid) begin
                        if (!w_last_bit) r_bit <= r_bit + BIT_INPUT_BIT_POSITION'(1);
                    end else if (w_wait_expired) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_sas_sequencer.sv
// Directed bench for cim_sas_sequencer: nominal runs, ones-count wrap, timeout,
// last-cycle acknowledge, ignored inputs and asynchronous reset mid-request.
module tb_cim_sas_sequencer;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [63:0]  ifm_in;
    logic [255:0] weight_pos_in;
    logic         adc_req;
    logic [2:0]   adc_bit;
    logic         adc_valid;
    logic [3:0]   adc_data;
    logic         in_valid;
    logic [3:0]   ADC_RESULT;
    logic [255:0] WEIGHT_BIT_POSITION;
    logic [2:0]   ONES_COUNTER;
    logic [2:0]   INPUT_BIT_POSITION;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         timeout_err;

    int           checks   = 0;
    int           failures = 0;
    logic [255:0] exp_wpos;
    logic         saw_done;

    cim_sas_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .ifm_in              (ifm_in),
        .weight_pos_in       (weight_pos_in),
        .adc_req             (adc_req),
        .adc_bit             (adc_bit),
        .adc_valid           (adc_valid),
        .adc_data            (adc_data),
        .in_valid            (in_valid),
        .ADC_RESULT          (ADC_RESULT),
        .WEIGHT_BIT_POSITION (WEIGHT_BIT_POSITION),
        .ONES_COUNTER        (ONES_COUNTER),
        .INPUT_BIT_POSITION  (INPUT_BIT_POSITION),
        .out_valid           (out_valid),
        .busy                (busy),
        .done                (done),
        .timeout_err         (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE; inputs are scrambled afterwards so only the latched copy can be seen.
    task automatic do_start(input logic [63:0] ifm, input logic [255:0] wpos);
        ifm_in        = ifm;
        weight_pos_in = wpos;
        exp_wpos      = wpos;
        start         = 1'b1;
        step();
        start         = 1'b0;
        ifm_in        = ~ifm;
        weight_pos_in = ~wpos;
    endtask

    // Entered in a REQ cycle; returns in the first WAIT cycle.
    task automatic issue_bit(input int b, input logic [2:0] exp_ones, input bit noisy);
        check("req_adc_req", 256'(adc_req), 256'(1));
        check("req_adc_bit", 256'(adc_bit), 256'(b));
        check("req_busy", 256'(busy), 256'(1));
        step();
        check("req_hold", 256'(adc_req), 256'(1));
        adc_valid = 1'b1;
        adc_data  = 4'(b);
        step();
        adc_valid = noisy;
        adc_data  = 4'hF;
        out_valid = noisy;
        start     = noisy;
        check("issue_in_valid", 256'(in_valid), 256'(1));
        check("issue_ones", 256'(ONES_COUNTER), 256'(exp_ones));
        check("issue_adc_result", 256'(ADC_RESULT), 256'(4'(b)));
        check("issue_bit_pos", 256'(INPUT_BIT_POSITION), 256'(b));
        check("issue_wpos", WEIGHT_BIT_POSITION, exp_wpos);
        check("issue_adc_req", 256'(adc_req), 256'(0));
        step();
        out_valid = 1'b0;
        adc_valid = noisy;
        start     = noisy;
        check("wait_in_valid", 256'(in_valid), 256'(0));
        check("wait_adc_req", 256'(adc_req), 256'(0));
        check("wait_busy", 256'(busy), 256'(1));
        check("wait_done", 256'(done), 256'(0));
    endtask

    // Acknowledge in WAIT cycle number sas_dly; returns in the following cycle.
    task automatic finish_bit(input int sas_dly);
        for (int i = 1; i < sas_dly; i++) begin
            step();
            adc_valid = 1'b0;
            start     = 1'b0;
        end
        out_valid = 1'b1;
        step();
        out_valid = 1'b0;
        adc_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic full_run(input logic [63:0] ifm, input logic [255:0] wpos,
                            input logic [23:0] ones_tbl, input int sas_dly, input int noisy_bit);
        do_start(ifm, wpos);
        for (int b = 0; b < 8; b++) begin
            issue_bit(b, ones_tbl[b*3 +: 3], (b == noisy_bit));
            finish_bit(sas_dly);
        end
        check("done_pulse", 256'(done), 256'(1));
        check("done_busy", 256'(busy), 256'(0));
        check("done_in_valid", 256'(in_valid), 256'(0));
        step();
        check("after_done", 256'(done), 256'(0));
        check("after_done_busy", 256'(busy), 256'(0));
        check("after_done_req", 256'(adc_req), 256'(0));
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        adc_valid     = 1'b0;
        out_valid     = 1'b0;
        adc_data      = '0;
        ifm_in        = '0;
        weight_pos_in = '0;
        exp_wpos      = '0;
        saw_done      = 1'b0;
        #3;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_timeout", 256'(timeout_err), 256'(0));
        check("rst_adc_req", 256'(adc_req), 256'(0));
        check("rst_in_valid", 256'(in_valid), 256'(0));
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_busy", 256'(busy), 256'(0));

        // IDLE must ignore handshake inputs.
        adc_valid = 1'b1;
        out_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        out_valid = 1'b0;
        check("idle_ign_in_valid", 256'(in_valid), 256'(0));
        check("idle_ign_adc_req", 256'(adc_req), 256'(0));
        check("idle_ign_busy", 256'(busy), 256'(0));

        // Row r holds r: bits 0..2 have four ones each, higher bits none; noise injected at bit 3.
        full_run(64'h0706050403020100, {32{8'hA5}}, 24'h000124, 2, 3);
        // Full slices of eight ones wrap to zero.
        full_run(64'hFFFFFFFFFFFFFFFF, {8{32'h01234567}}, 24'h000000, 1, -1);
        // Seven ones on bit 0 is the largest representable count.
        full_run(64'h0001010101010101, {32{8'h3C}}, 24'h000007, 1, -1);

        // Timeout: no acknowledge for 100 WAIT cycles.
        do_start(64'h0706050403020100, {32{8'h5A}});
        issue_bit(0, 3'd4, 1'b0);
        for (int i = 2; i <= 100; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("to_last_wait_busy", 256'(busy), 256'(1));
        check("to_last_wait_err", 256'(timeout_err), 256'(0));
        check("to_last_wait_req", 256'(adc_req), 256'(0));
        step();
        check("to_err", 256'(timeout_err), 256'(1));
        check("to_busy", 256'(busy), 256'(0));
        check("to_done", 256'(done), 256'(0));
        step();
        if (done) saw_done = 1'b1;
        step();
        if (done) saw_done = 1'b1;
        check("to_no_done", 256'(saw_done), 256'(0));
        check("to_err_sticky", 256'(timeout_err), 256'(1));
        check("to_idle_in_valid", 256'(in_valid), 256'(0));

        // Next start clears the error; acknowledge on the 100th WAIT cycle still succeeds.
        do_start(64'h0100000000000001, {32{8'hC3}});
        check("restart_err_clr", 256'(timeout_err), 256'(0));
        issue_bit(0, 3'd2, 1'b0);
        finish_bit(100);
        check("edge_no_timeout", 256'(timeout_err), 256'(0));
        check("edge_busy", 256'(busy), 256'(1));
        check("edge_next_req", 256'(adc_req), 256'(1));
        check("edge_next_bit", 256'(adc_bit), 256'(1));

        // Asynchronous reset in the middle of a REQ cycle.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_adc_req", 256'(adc_req), 256'(0));
        check("arst_adc_bit", 256'(adc_bit), 256'(0));
        check("arst_busy", 256'(busy), 256'(0));
        check("arst_in_valid", 256'(in_valid), 256'(0));
        check("arst_done", 256'(done), 256'(0));
        check("arst_timeout", 256'(timeout_err), 256'(0));
        check("arst_adc_result", 256'(ADC_RESULT), 256'(0));
        check("arst_ones", 256'(ONES_COUNTER), 256'(0));
        check("arst_bit_pos", 256'(INPUT_BIT_POSITION), 256'(0));
        check("arst_wpos", WEIGHT_BIT_POSITION, 256'(0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_in_valid", 256'(in_valid), 256'(0));
            check("post_rst_busy", 256'(busy), 256'(0));
            check("post_rst_adc_req", 256'(adc_req), 256'(0));
        end

        // Clean restart after reset, minimum per-bit latency.
        full_run(64'h0706050403020100, {32{8'h96}}, 24'h000124, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cim_sas_sequencer.md
# cim_sas_sequencer

Bit-serial sequencer that drives the Shift_and_Add block of the CIM macro datapath. On `start` it latches an OUY-row input-feature-map slice and the per-filter weight bit positions. For each input bit position 0..BIT_IFM-1 it fetches an ADC conversion, computes that slice's ones count, and issues one `in_valid` beat to Shift_and_Add. It waits for Shift_and_Add's `out_valid` before issuing the next bit, with a bounded-wait timeout.

## Interface
- BIT_CELL, 1, bits per memory cell
- BIT_DAC, 1, bits per DAC input
- BIT_W, 8, weight precision
- OUY, 8, rows activated per operation unit
- BIT_IFM, 8, input feature map precision
- MAX_NUM_FILTER, 32, filters per weight-position bus
- MAX_WAIT, 100, WAIT-state cycles allowed before timeout
- Derived values:
  - ADC_PRECISION = BIT_CELL+BIT_DAC+$clog2(OUY), minus 1 when BIT_CELL==1 or BIT_DAC==1 (4 at defaults)
  - BIT_ONES_COUNTER = $clog2(OUY)
  - BIT_INPUT_BIT_POSITION = $clog2(BIT_IFM)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sequence; sampled only in IDLE
- ifm_in  in  OUY*BIT_IFM  row r at [r*BIT_IFM +: BIT_IFM]; latched on accepted start
- weight_pos_in  in  MAX_NUM_FILTER*BIT_W  latched on accepted start
- adc_req  out  1  request a conversion for bit `adc_bit`
- adc_bit  out  BIT_INPUT_BIT_POSITION  bit position being converted
- adc_valid  in  1  conversion result present; honoured only in REQ
- adc_data  in  ADC_PRECISION  conversion result
- in_valid  out  1  one-cycle beat to Shift_and_Add
- ADC_RESULT  out  ADC_PRECISION  captured adc_data
- WEIGHT_BIT_POSITION  out  MAX_NUM_FILTER*BIT_W  latched weight_pos_in
- ONES_COUNTER  out  BIT_ONES_COUNTER  popcount of current bit slice
- INPUT_BIT_POSITION  out  BIT_INPUT_BIT_POSITION  current bit
- out_valid  in  1  Shift_and_Add result done; honoured only in WAIT
- busy  out  1  high from the cycle after an accepted start until DONE or timeout
- done  out  1  one-cycle pulse after the last bit completes
- timeout_err  out  1  sticky error flag; cleared by the next accepted start

## Operation
- States: IDLE, REQ, ISSUE, WAIT, DONE.
- IDLE:
  - start=1: latch ifm_in and weight_pos_in, set bit=0, clear timeout_err, go to REQ.
  - start is ignored in every state other than IDLE.
- REQ:
  - adc_req=1 and adc_bit=bit.
  - adc_valid=1: capture adc_data, go to ISSUE. adc_req is low from the next cycle.
- ISSUE: for exactly one cycle drive:
  - in_valid=1
  - ADC_RESULT=captured data
  - INPUT_BIT_POSITION=bit
  - WEIGHT_BIT_POSITION=latched value
  - ONES_COUNTER = (number of rows r with ifm[r][bit]=1) mod 2^BIT_ONES_COUNTER. A full slice of OUY ones wraps to 0; this is fixed by the Shift_and_Add port width.
  - Then go to WAIT with wait_cnt=0.
- WAIT:
  - out_valid=1 and bit==BIT_IFM-1: go to DONE.
  - out_valid=1 otherwise: bit++, go to REQ.
  - out_valid=0 and wait_cnt==MAX_WAIT-1: set timeout_err=1, go to IDLE. done is not pulsed.
  - out_valid=0 otherwise: wait_cnt++.
  - out_valid on the final allowed cycle counts as success.
- DONE: done=1 for one cycle, then go to IDLE.
- Output values when not in the states above:
  - in_valid=0.
  - ADC_RESULT, ONES_COUNTER, INPUT_BIT_POSITION and WEIGHT_BIT_POSITION drive 0.
  - adc_bit drives 0 outside REQ.

## Timing
- Reset (asynchronous, any state): state=IDLE; every output 0, including busy, done and timeout_err. Latched data and counters are cleared; any in-flight sequence is abandoned.
- Start accepted at edge t: busy=1 and adc_req=1 from t+1.
- adc_valid sampled at edge t in REQ: in_valid=1 during cycle t+1.
- out_valid sampled at edge u in WAIT:
  - next adc_req during cycle u+1, or
  - done during cycle u+1 for the last bit. busy drops with the done cycle.
- Minimum per-bit cost is 3 cycles (REQ 1, ISSUE 1, WAIT 1).
- Timeout: exactly MAX_WAIT WAIT cycles without out_valid. timeout_err rises, and busy falls, on the following edge.

## Test plan
- Reset: assert rst_n=0 mid-REQ -> all outputs 0 immediately; after release, in_valid stays 0 without a start.
- Nominal run:
  - Stimulus: ifm row r = r (r=0..7); ADC model returns data=bit one cycle after adc_req; Shift_and_Add model asserts out_valid 2 cycles after in_valid.
  - Required: 8 beats with INPUT_BIT_POSITION 0..7, ONES_COUNTER 4,4,4,0,0,0,0,0, ADC_RESULT = bit.
  - done pulses once, 1 cycle after the 8th out_valid.
- Wrap: all ifm rows 8'hFF -> ONES_COUNTER=0 on every beat. Rows 8'h01 on rows 0..6 only -> ONES_COUNTER=7 at bit 0.
- Timeout:
  - out_valid never asserted -> timeout_err=1 exactly 100 cycles after entering WAIT; busy=0; done never pulses.
  - Next start clears timeout_err.
- Boundary timing: out_valid on the 100th WAIT cycle -> no timeout, sequence continues.
- Ignored inputs: start pulses while busy, adc_valid outside REQ, and out_valid during ISSUE -> no extra in_valid beats and no state change.
